// File: rtl/fringe_arria10_top.sv
// rtl/fringe_arria10_top.sv - Arria10 accelerator shell: Avalon register file, sum kernel, AXI4 master, debug scratch
// Optional feature macro: AXI_WRITEBACK_EN (single-beat write of the result to DRAM before DONE)
module fringe_arria10_top #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int AXI_DW = 512,
    parameter int AXI_SW = AXI_DW / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_raddr,
    input  logic              io_waddr,
    input  logic              io_wen,
    output logic              io_rdata,
    input  logic [ADDR_W-1:0] io_S_AVALON_address,
    input  logic              io_S_AVALON_chipselect,
    input  logic              io_S_AVALON_write,
    input  logic              io_S_AVALON_read,
    input  logic [DATA_W-1:0] io_S_AVALON_writedata,
    output logic [DATA_W-1:0] io_S_AVALON_readdata,
    output logic [5:0]        io_M_AXI_0_AWID,
    output logic [31:0]       io_M_AXI_0_AWUSER,
    output logic [31:0]       io_M_AXI_0_AWADDR,
    output logic [7:0]        io_M_AXI_0_AWLEN,
    output logic [2:0]        io_M_AXI_0_AWSIZE,
    output logic [1:0]        io_M_AXI_0_AWBURST,
    output logic              io_M_AXI_0_AWLOCK,
    output logic [3:0]        io_M_AXI_0_AWCACHE,
    output logic [2:0]        io_M_AXI_0_AWPROT,
    output logic [3:0]        io_M_AXI_0_AWQOS,
    output logic              io_M_AXI_0_AWVALID,
    input  logic              io_M_AXI_0_AWREADY,
    output logic [5:0]        io_M_AXI_0_ARID,
    output logic [31:0]       io_M_AXI_0_ARUSER,
    output logic [31:0]       io_M_AXI_0_ARADDR,
    output logic [7:0]        io_M_AXI_0_ARLEN,
    output logic [2:0]        io_M_AXI_0_ARSIZE,
    output logic [1:0]        io_M_AXI_0_ARBURST,
    output logic              io_M_AXI_0_ARLOCK,
    output logic [3:0]        io_M_AXI_0_ARCACHE,
    output logic [2:0]        io_M_AXI_0_ARPROT,
    output logic [3:0]        io_M_AXI_0_ARQOS,
    output logic              io_M_AXI_0_ARVALID,
    input  logic              io_M_AXI_0_ARREADY,
    output logic [AXI_DW-1:0] io_M_AXI_0_WDATA,
    output logic [AXI_SW-1:0] io_M_AXI_0_WSTRB,
    output logic              io_M_AXI_0_WLAST,
    output logic              io_M_AXI_0_WVALID,
    input  logic              io_M_AXI_0_WREADY,
    input  logic [5:0]        io_M_AXI_0_RID,
    input  logic [31:0]       io_M_AXI_0_RUSER,
    input  logic [AXI_DW-1:0] io_M_AXI_0_RDATA,
    input  logic [1:0]        io_M_AXI_0_RRESP,
    input  logic              io_M_AXI_0_RLAST,
    input  logic              io_M_AXI_0_RVALID,
    output logic              io_M_AXI_0_RREADY,
    input  logic [5:0]        io_M_AXI_0_BID,
    input  logic [31:0]       io_M_AXI_0_BUSER,
    input  logic [1:0]        io_M_AXI_0_BRESP,
    input  logic              io_M_AXI_0_BVALID,
    output logic              io_M_AXI_0_BREADY
);
    localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ARGIN0 = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_ARGOUT = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_ARGIN1 = ADDR_W'(4);
    localparam logic [DATA_W:0]   CNT_ONE  = {{DATA_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef AXI_WRITEBACK_EN
        , S_WB = 2'd3
`endif
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_cmd;
    logic [DATA_W-1:0] r_argin0;
    logic [DATA_W-1:0] r_argin1;
    logic [DATA_W-1:0] r_argout0;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W:0]   r_cnt;      // one extra bit so cnt can exceed N = 2^32-1
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_readdata;
    logic [1:0]        r_mem;
    logic [DATA_W-1:0] w_status;
    logic              w_unused;
`ifdef AXI_WRITEBACK_EN
    logic              r_awvalid;
    logic              r_wvalid;
`endif

    assign w_status = {{(DATA_W-2){1'b0}}, r_busy, r_done};

    // Host writes to the RW registers; chipselect is deliberately not decoded
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd    <= '0;
            r_argin0 <= '0;
            r_argin1 <= '0;
        end else if (io_S_AVALON_write) begin
            case (io_S_AVALON_address)
                A_CMD:    r_cmd    <= io_S_AVALON_writedata;
                A_ARGIN0: r_argin0 <= io_S_AVALON_writedata;
                A_ARGIN1: r_argin1 <= io_S_AVALON_writedata;
                default:  ;
            endcase
        end
    end

    // Read data registered every edge regardless of the read strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else begin
            case (io_S_AVALON_address)
                A_CMD:    r_readdata <= r_cmd;
                A_STATUS: r_readdata <= w_status;
                A_ARGIN0: r_readdata <= r_argin0;
                A_ARGOUT: r_readdata <= r_argout0;
                A_ARGIN1: r_readdata <= r_argin1;
                default:  r_readdata <= '0;
            endcase
        end
    end

    // Kernel control: sum 1..N with a live N compare, optional DRAM write-back, done handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_argout0 <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef AXI_WRITEBACK_EN
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd[0] && !r_done) begin
                        r_cnt   <= CNT_ONE;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt <= {1'b0, r_argin0}) begin
                        r_acc <= r_acc + r_cnt[DATA_W-1:0];
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_argout0 <= r_acc;
`ifdef AXI_WRITEBACK_EN
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WB;
`else
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end
                end
`ifdef AXI_WRITEBACK_EN
                S_WB: begin
                    if (r_awvalid && io_M_AXI_0_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && io_M_AXI_0_WREADY)   r_wvalid  <= 1'b0;
                    // response only counts once both address and data have been accepted
                    if (!r_awvalid && !r_wvalid && io_M_AXI_0_BVALID) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (!r_cmd[0]) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Debug scratch: each write-enabled edge flips the addressed bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem <= 2'b00;
        end else if (io_wen) begin
            r_mem[io_waddr] <= ~r_mem[io_waddr];
        end
    end

    assign io_rdata             = r_mem[io_raddr];
    assign io_S_AVALON_readdata = r_readdata;

`ifdef AXI_WRITEBACK_EN
    assign io_M_AXI_0_AWADDR  = {r_argin1[31:6], 6'b0};
    assign io_M_AXI_0_AWSIZE  = 3'd6;
    assign io_M_AXI_0_AWBURST = 2'b01;
    assign io_M_AXI_0_AWCACHE = 4'b0011;
    assign io_M_AXI_0_AWVALID = r_awvalid;
    assign io_M_AXI_0_WDATA   = {{(AXI_DW-DATA_W){1'b0}}, r_argout0};
    assign io_M_AXI_0_WSTRB   = {{(AXI_SW-4){1'b0}}, 4'hF};
    assign io_M_AXI_0_WLAST   = 1'b1;
    assign io_M_AXI_0_WVALID  = r_wvalid;
`else
    assign io_M_AXI_0_AWADDR  = '0;
    assign io_M_AXI_0_AWSIZE  = '0;
    assign io_M_AXI_0_AWBURST = '0;
    assign io_M_AXI_0_AWCACHE = '0;
    assign io_M_AXI_0_AWVALID = 1'b0;
    assign io_M_AXI_0_WDATA   = '0;
    assign io_M_AXI_0_WSTRB   = '0;
    assign io_M_AXI_0_WLAST   = 1'b0;
    assign io_M_AXI_0_WVALID  = 1'b0;
`endif
    assign io_M_AXI_0_AWID    = '0;
    assign io_M_AXI_0_AWUSER  = '0;
    assign io_M_AXI_0_AWLEN   = '0;
    assign io_M_AXI_0_AWLOCK  = 1'b0;
    assign io_M_AXI_0_AWPROT  = '0;
    assign io_M_AXI_0_AWQOS   = '0;
    assign io_M_AXI_0_ARID    = '0;
    assign io_M_AXI_0_ARUSER  = '0;
    assign io_M_AXI_0_ARADDR  = '0;
    assign io_M_AXI_0_ARLEN   = '0;
    assign io_M_AXI_0_ARSIZE  = '0;
    assign io_M_AXI_0_ARBURST = '0;
    assign io_M_AXI_0_ARLOCK  = 1'b0;
    assign io_M_AXI_0_ARCACHE = '0;
    assign io_M_AXI_0_ARPROT  = '0;
    assign io_M_AXI_0_ARQOS   = '0;
    assign io_M_AXI_0_ARVALID = 1'b0;
    assign io_M_AXI_0_RREADY  = 1'b1;
    assign io_M_AXI_0_BREADY  = 1'b1;

    // Inputs with no consumer in this shell (read channel, B id/user/resp, strobes)
    assign w_unused = ^{io_S_AVALON_chipselect, io_S_AVALON_read, io_M_AXI_0_ARREADY,
                        io_M_AXI_0_AWREADY, io_M_AXI_0_WREADY, io_M_AXI_0_BVALID,
                        io_M_AXI_0_RID, io_M_AXI_0_RUSER, io_M_AXI_0_RDATA, io_M_AXI_0_RRESP,
                        io_M_AXI_0_RLAST, io_M_AXI_0_RVALID, io_M_AXI_0_BID, io_M_AXI_0_BUSER,
                        io_M_AXI_0_BRESP, r_argin1[5:0]};
endmodule

// File: tb/tb_fringe_arria10_top.sv
// tb/tb_fringe_arria10_top.sv - directed self-checking bench for fringe_arria10_top
module tb_fringe_arria10_top;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         io_raddr = 1'b0, io_waddr = 1'b0, io_wen = 1'b0;
    logic         io_rdata;
    logic [6:0]   av_address = '0;
    logic         av_chipselect = 1'b0, av_write = 1'b0, av_read = 1'b0;
    logic [31:0]  av_writedata = '0;
    logic [31:0]  av_readdata;
    logic [5:0]   aw_id, ar_id;
    logic [31:0]  aw_user, aw_addr, ar_user, ar_addr;
    logic [7:0]   aw_len, ar_len;
    logic [2:0]   aw_size, aw_prot, ar_size, ar_prot;
    logic [1:0]   aw_burst, ar_burst;
    logic         aw_lock, aw_valid, ar_lock, ar_valid;
    logic [3:0]   aw_cache, aw_qos, ar_cache, ar_qos;
    logic         aw_ready = 1'b0, ar_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
    logic [511:0] w_data;
    logic [63:0]  w_strb;
    logic         w_last, w_valid, r_ready, b_ready;
    logic [5:0]   r_id = '0, b_id = '0;
    logic [31:0]  r_user = '0, b_user = '0;
    logic [511:0] r_data = '0;
    logic [1:0]   r_resp = '0, b_resp = '0;
    logic         r_last = 1'b0, r_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs    = 0;
    int ready_delay = 0, b_delay = 0;
    logic [31:0] sl_addr = '0, sl_wdata = '0;
    logic [63:0] sl_strb = '0;
    logic [10:0] sl_lsb = '0;
    logic        hold_ok = 1'b0, drop_ok = 1'b0, done_early = 1'b1;

    fringe_arria10_top dut (
        .clock(clock), .reset(reset),
        .io_raddr(io_raddr), .io_waddr(io_waddr), .io_wen(io_wen), .io_rdata(io_rdata),
        .io_S_AVALON_address(av_address), .io_S_AVALON_chipselect(av_chipselect),
        .io_S_AVALON_write(av_write), .io_S_AVALON_read(av_read),
        .io_S_AVALON_writedata(av_writedata), .io_S_AVALON_readdata(av_readdata),
        .io_M_AXI_0_AWID(aw_id), .io_M_AXI_0_AWUSER(aw_user), .io_M_AXI_0_AWADDR(aw_addr),
        .io_M_AXI_0_AWLEN(aw_len), .io_M_AXI_0_AWSIZE(aw_size), .io_M_AXI_0_AWBURST(aw_burst),
        .io_M_AXI_0_AWLOCK(aw_lock), .io_M_AXI_0_AWCACHE(aw_cache), .io_M_AXI_0_AWPROT(aw_prot),
        .io_M_AXI_0_AWQOS(aw_qos), .io_M_AXI_0_AWVALID(aw_valid), .io_M_AXI_0_AWREADY(aw_ready),
        .io_M_AXI_0_ARID(ar_id), .io_M_AXI_0_ARUSER(ar_user), .io_M_AXI_0_ARADDR(ar_addr),
        .io_M_AXI_0_ARLEN(ar_len), .io_M_AXI_0_ARSIZE(ar_size), .io_M_AXI_0_ARBURST(ar_burst),
        .io_M_AXI_0_ARLOCK(ar_lock), .io_M_AXI_0_ARCACHE(ar_cache), .io_M_AXI_0_ARPROT(ar_prot),
        .io_M_AXI_0_ARQOS(ar_qos), .io_M_AXI_0_ARVALID(ar_valid), .io_M_AXI_0_ARREADY(ar_ready),
        .io_M_AXI_0_WDATA(w_data), .io_M_AXI_0_WSTRB(w_strb), .io_M_AXI_0_WLAST(w_last),
        .io_M_AXI_0_WVALID(w_valid), .io_M_AXI_0_WREADY(w_ready),
        .io_M_AXI_0_RID(r_id), .io_M_AXI_0_RUSER(r_user), .io_M_AXI_0_RDATA(r_data),
        .io_M_AXI_0_RRESP(r_resp), .io_M_AXI_0_RLAST(r_last), .io_M_AXI_0_RVALID(r_valid),
        .io_M_AXI_0_RREADY(r_ready),
        .io_M_AXI_0_BID(b_id), .io_M_AXI_0_BUSER(b_user), .io_M_AXI_0_BRESP(b_resp),
        .io_M_AXI_0_BVALID(b_valid), .io_M_AXI_0_BREADY(b_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (aw_valid && aw_ready) aw_hs <= aw_hs + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clock);
        av_address = a; av_writedata = d; av_write = 1'b1;
        @(negedge clock);
        av_write = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge clock);
        av_address = a;
        @(negedge clock);
        d = av_readdata;
    endtask

    // Watch STATUS.done; k counts negedges from the call until done is seen
    task automatic wait_done(input string tag, input int budget, output int k);
        bit found;
        found = 1'b0;
        k = 0;
        av_address = 7'd1;
        while (!found && k < budget) begin
            @(negedge clock);
            k++;
            if (av_readdata[0]) found = 1'b1;
        end
        check(tag, {63'b0, found}, 64'd1);
    endtask

`ifdef AXI_WRITEBACK_EN
    // AXI write slave with programmable READY and B delays
    initial begin : axi_slave
        forever begin
            @(negedge clock);
            if (aw_valid) begin
                sl_addr = aw_addr; sl_wdata = w_data[31:0]; sl_strb = w_strb;
                sl_lsb = {aw_len, aw_size};
                hold_ok = 1'b1;
                repeat (ready_delay) begin
                    @(negedge clock);
                    if (!(aw_valid && w_valid)) hold_ok = 1'b0;
                end
                aw_ready = 1'b1; w_ready = 1'b1;
                @(negedge clock);
                aw_ready = 1'b0; w_ready = 1'b0;
                drop_ok = !aw_valid && !w_valid;
                repeat (b_delay) @(negedge clock);
                done_early = av_readdata[0];
                b_valid = 1'b1;
                @(negedge clock);
                b_valid = 1'b0;
            end
        end
    end
`endif

    initial begin
        logic [31:0] d;
        int k;
        int hs0;
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_readdata", {32'b0, av_readdata}, 64'd0);
        check("rst_io_rdata", {63'b0, io_rdata}, 64'd0);
        check("rst_valids", {61'b0, aw_valid, w_valid, ar_valid}, 64'd0);
        check("rst_readies", {62'b0, r_ready, b_ready}, 64'd3);
        check("ar_zero", {63'b0, |{ar_id, ar_user, ar_addr, ar_len, ar_size, ar_burst,
                                   ar_lock, ar_cache, ar_prot, ar_qos}}, 64'd0);
        check("aw_misc_zero", {63'b0, |{aw_id, aw_user, aw_lock, aw_prot, aw_qos}}, 64'd0);
        reset = 1'b1;
        rd(7'd1, d); check("rst_status", {32'b0, d}, 64'd0);

        // Sum of 1..4
        wr(7'd2, 32'd4);
        wr(7'd0, 32'd1);
        repeat (50) @(negedge clock);
        rd(7'd3, d); check("n4_argout", {32'b0, d}, 64'd10);
        rd(7'd1, d); check("n4_status", {32'b0, d}, 64'd1);
        rd(7'd2, d); check("argin0_rb", {32'b0, d}, 64'd4);
        rd(7'd0, d); check("cmd_rb", {32'b0, d}, 64'd1);
        wr(7'd3, 32'h55);
        rd(7'd3, d); check("argout_ro", {32'b0, d}, 64'd10);
        wr(7'd5, 32'hDEAD);
        rd(7'd5, d); check("unmapped", {32'b0, d}, 64'd0);
        rd(7'd1, d); check("held_done", {32'b0, d}, 64'd1);
        wr(7'd0, 32'd0);
        rd(7'd1, d); check("n4_clear", {32'b0, d}, 64'd0);

        // N = 0
        wr(7'd2, 32'd0);
        wr(7'd0, 32'd1);
        wait_done("n0_done", 20, k);
`ifndef AXI_WRITEBACK_EN
        check("n0_latency", 64'(k), 64'd3);
`endif
        rd(7'd3, d); check("n0_argout", {32'b0, d}, 64'd0);
        wr(7'd0, 32'd0);
        rd(7'd1, d); check("n0_clear", {32'b0, d}, 64'd0);

        // 32-bit wrap with N = 0x10000
        wr(7'd2, 32'h10000);
        wr(7'd0, 32'd1);
        repeat (5) @(negedge clock);
        rd(7'd1, d); check("busy_run", {32'b0, d}, 64'd2);
        check("run_valids", {62'b0, aw_valid, w_valid}, 64'd0);
        wait_done("wrap_done", 70000, k);
        rd(7'd3, d); check("wrap_argout", {32'b0, d}, 64'h80008000);
        wr(7'd0, 32'd0);
        rd(7'd1, d); check("wrap_clear", {32'b0, d}, 64'd0);

        // Debug scratch toggling
        @(negedge clock); io_wen = 1'b1; io_waddr = 1'b1;
        @(negedge clock); io_wen = 1'b0;
        io_raddr = 1'b1; #1 check("scr_bit1", {63'b0, io_rdata}, 64'd1);
        io_raddr = 1'b0; #1 check("scr_bit0", {63'b0, io_rdata}, 64'd0);
        @(negedge clock); io_wen = 1'b1; io_waddr = 1'b1;
        @(negedge clock); io_wen = 1'b0;
        io_raddr = 1'b1; #1 check("scr_bit1_again", {63'b0, io_rdata}, 64'd0);

`ifdef AXI_WRITEBACK_EN
        // Write-back with delayed READY and B
        hs0 = aw_hs;
        ready_delay = 2; b_delay = 3;
        wr(7'd4, 32'h1040);
        wr(7'd2, 32'd3);
        wr(7'd0, 32'd1);
        wait_done("wb_done", 100, k);
        rd(7'd3, d); check("wb_argout", {32'b0, d}, 64'd6);
        check("wb_awaddr", {32'b0, sl_addr}, 64'h1040);
        check("wb_wdata", {32'b0, sl_wdata}, 64'd6);
        check("wb_wstrb", sl_strb, 64'hF);
        check("wb_len_size", {53'b0, sl_lsb}, 64'd6);
        check("wb_hold", {63'b0, hold_ok}, 64'd1);
        check("wb_drop", {63'b0, drop_ok}, 64'd1);
        check("wb_done_early", {63'b0, done_early}, 64'd0);
        check("wb_aw_count", 64'(aw_hs - hs0), 64'd1);
        wr(7'd0, 32'd0);
`else
        hs0 = aw_hs;
        check("no_aw_hs", 64'(hs0), 64'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
